// File: rtl/operand_packer.sv
// Collects narrow operand words (least-significant word first) into one wide operand
// and pushes it to the operand FIFO with a single-cycle write strobe.
module operand_packer #(
  parameter int Data = 512,
  parameter int Word = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Word-1:0] word_in,
  input  logic            word_valid,
  input  logic            word_last,
  output logic            word_ready,
  input  logic            fifo_in_busy,
  output logic            fifo_wr_en,
  output logic [Data-1:0] fifo_data,
  output logic [15:0]     op_count
);

  localparam int N    = Data / Word;
  localparam int IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PUSH = 1'b1;

  logic [0:0]      state;
  logic [IdxW-1:0] idx;
  logic [Data-1:0] asm_buf;

  // Outputs decode from state and the FIFO full flag only, never from the word inputs.
  assign word_ready = (state == FILL);
  assign fifo_wr_en = (state == PUSH) && !fifo_in_busy;
  assign fifo_data  = asm_buf;

  // Clearing the buffer on every return to FILL gives zero padding for short operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      idx      <= '0;
      asm_buf  <= '0;
      op_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (word_valid) begin
            asm_buf[idx*Word +: Word] <= word_in;
            if (idx == LastIdx || word_last) begin
              state <= PUSH;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PUSH: begin
          if (!fifo_in_busy) begin
            state    <= FILL;
            op_count <= op_count + 16'd1;
            asm_buf  <= '0;
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
